// File: rtl/uart_tx_serializer.sv
// UART 8N1 transmitter with a one-deep holding buffer and a sticky overflow flag.
`timescale 1ns/1ps
module uart_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       CLOCK,
  input  logic       reset,
  input  logic [7:0] tx_data_in,
  input  logic       Wr_en,
  input  logic       clr_ovrflw,
  output logic       Tx,
  output logic       buf_full,
  output logic       tx_busy,
  output logic       overflow
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 3;
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic [DATA_W-1:0]   shift, shift_n;
  logic [DATA_W-1:0]   hold, hold_n;
  logic                tx_n, buf_full_n, busy_n, ovf_n;
  logic                bit_end, load;

  // State and output registers; reset abandons any frame in progress.
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shift    <= '0;
      hold     <= '0;
      Tx       <= 1'b1;
      buf_full <= 1'b0;
      tx_busy  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      shift    <= shift_n;
      hold     <= hold_n;
      Tx       <= tx_n;
      buf_full <= buf_full_n;
      tx_busy  <= busy_n;
      overflow <= ovf_n;
    end
  end

  // Next-state, buffer handling and next output values.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    shift_n    = shift;
    hold_n     = hold;
    buf_full_n = buf_full;
    ovf_n      = overflow;
    load       = 1'b0;
    tx_n       = 1'b1;
    busy_n     = 1'b0;
    bit_end    = (cnt == BIT_END);

    case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (buf_full) begin
          load    = 1'b1;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n   = '0;
          shift_n = shift >> 1;
          if (idx == LAST_BIT) begin
            state_n = STOP;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          if (buf_full) begin
            load    = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    if (load) begin
      shift_n    = hold;
      buf_full_n = 1'b0;
    end

    // A write on the load edge refills the buffer the FSM is emptying.
    if (Wr_en) begin
      if (!buf_full || load) begin
        hold_n     = tx_data_in;
        buf_full_n = 1'b1;
      end else begin
        ovf_n = 1'b1;
      end
    end
    if (clr_ovrflw) begin
      ovf_n = 1'b0;
    end

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with a line-side frame decoder.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

  logic       CLOCK;
  logic       reset;
  logic [7:0] tx_data_in;
  logic       Wr_en;
  logic       clr_ovrflw;
  logic       Tx;
  logic       buf_full;
  logic       tx_busy;
  logic       overflow;

  int vec_count  = 0;
  int miss_count = 0;

  logic [7:0] rx_q[$];
  int         gap_q[$];
  int         err_q[$];

  uart_tx_serializer #(.CLKS_PER_BIT(4), .CNT_W(4)) dut (
    .CLOCK      (CLOCK),
    .reset      (reset),
    .tx_data_in (tx_data_in),
    .Wr_en      (Wr_en),
    .clr_ovrflw (clr_ovrflw),
    .Tx         (Tx),
    .buf_full   (buf_full),
    .tx_busy    (tx_busy),
    .overflow   (overflow)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miss_count++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle write strobe; returns on the falling edge after the write edge.
  task automatic write_byte(input logic [7:0] b);
    @(negedge CLOCK);
    tx_data_in = b;
    Wr_en      = 1'b1;
    @(negedge CLOCK);
    Wr_en      = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] exp, input logic gap0);
    int t;
    int gap;
    int err;
    logic [7:0] d;
    t = 0;
    while (rx_q.size() == 0 && t < 300) begin
      @(negedge CLOCK);
      t++;
    end
    check({tag, "_rx"}, 32'(rx_q.size() != 0), 32'd1);
    if (rx_q.size() != 0) begin
      d   = rx_q.pop_front();
      gap = gap_q.pop_front();
      err = err_q.pop_front();
      check({tag, "_data"}, 32'(d), 32'(exp));
      check({tag, "_shape"}, 32'(err), 32'd0);
      if (gap0) check({tag, "_gap"}, 32'(gap), 32'd0);
    end
  endtask

  // Line decoder: samples each bit 4 times, records byte, idle gap and shape errors.
  initial begin : rx_mon
    int idle_run;
    int err;
    logic abort;
    logic [9:0] bits;
    idle_run = 0;
    forever begin
      @(negedge CLOCK);
      if (reset) begin
        idle_run = 0;
      end else if (Tx !== 1'b0) begin
        idle_run++;
      end else begin
        err   = 0;
        abort = 1'b0;
        bits  = '0;
        for (int b = 0; b < 10; b++) begin
          for (int k = 0; k < 4; k++) begin
            if (b != 0 || k != 0) @(negedge CLOCK);
            if (reset) begin
              abort = 1'b1;
              break;
            end
            if (k == 0) bits[b] = Tx;
            else if (Tx !== bits[b]) err++;
            if (tx_busy !== 1'b1) err++;
          end
          if (abort) break;
        end
        if (bits[0] !== 1'b0) err++;
        if (bits[9] !== 1'b1) err++;
        if (!abort) begin
          rx_q.push_back(bits[8:1]);
          gap_q.push_back(idle_run);
          err_q.push_back(err);
        end
        idle_run = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    tx_data_in = '0;
    Wr_en      = 1'b0;
    clr_ovrflw = 1'b0;
    repeat (3) @(negedge CLOCK);
    check("rst_tx", 32'(Tx), 32'd1);
    check("rst_full", 32'(buf_full), 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge CLOCK);

    // Single byte A5: latency, frame shape, busy length.
    write_byte(8'hA5);
    check("t1_full_n", 32'(buf_full), 32'd1);
    check("t1_tx_n", 32'(Tx), 32'd1);
    check("t1_busy_n", 32'(tx_busy), 32'd0);
    @(negedge CLOCK);
    check("t1_tx_n1", 32'(Tx), 32'd0);
    check("t1_busy_n1", 32'(tx_busy), 32'd1);
    check("t1_full_n1", 32'(buf_full), 32'd0);
    repeat (39) @(negedge CLOCK);
    check("t1_busy_last", 32'(tx_busy), 32'd1);
    @(negedge CLOCK);
    check("t1_busy_after", 32'(tx_busy), 32'd0);
    check("t1_tx_after", 32'(Tx), 32'd1);
    expect_frame("t1", 8'hA5, 1'b0);

    // Back-to-back 00 then FF with no idle gap.
    repeat (4) @(negedge CLOCK);
    write_byte(8'h00);
    repeat (10) @(negedge CLOCK);
    write_byte(8'hFF);
    repeat (28) @(negedge CLOCK);
    check("t2_full_stop", 32'(buf_full), 32'd1);
    @(negedge CLOCK);
    check("t2_full_start", 32'(buf_full), 32'd0);
    check("t2_tx_start", 32'(Tx), 32'd0);
    expect_frame("t2a", 8'h00, 1'b0);
    expect_frame("t2b", 8'hFF, 1'b1);

    // Overflow burst 11,22,33 from idle; 33 is dropped.
    repeat (10) @(negedge CLOCK);
    @(negedge CLOCK);
    tx_data_in = 8'h11;
    Wr_en      = 1'b1;
    @(negedge CLOCK);
    tx_data_in = 8'h22;
    @(negedge CLOCK);
    tx_data_in = 8'h33;
    @(negedge CLOCK);
    Wr_en      = 1'b0;
    check("t3_ovf_set", 32'(overflow), 32'd1);
    check("t3_full", 32'(buf_full), 32'd1);
    expect_frame("t3a", 8'h11, 1'b0);
    expect_frame("t3b", 8'h22, 1'b1);
    repeat (5) @(negedge CLOCK);
    check("t3_ovf_sticky", 32'(overflow), 32'd1);
    clr_ovrflw = 1'b1;
    @(negedge CLOCK);
    clr_ovrflw = 1'b0;
    check("t3_ovf_clr", 32'(overflow), 32'd0);

    // Simultaneous overflow set and clear leaves the flag clear.
    write_byte(8'h44);
    repeat (10) @(negedge CLOCK);
    write_byte(8'h55);
    @(negedge CLOCK);
    tx_data_in = 8'h66;
    Wr_en      = 1'b1;
    clr_ovrflw = 1'b1;
    @(negedge CLOCK);
    Wr_en      = 1'b0;
    clr_ovrflw = 1'b0;
    check("t3_setclr_ovf", 32'(overflow), 32'd0);
    check("t3_setclr_full", 32'(buf_full), 32'd1);
    expect_frame("t3c", 8'h44, 1'b0);
    expect_frame("t3d", 8'h55, 1'b1);
    repeat (60) @(negedge CLOCK);
    check("t3_no_extra", 32'(rx_q.size()), 32'd0);
    check("t3_drained", 32'(buf_full), 32'd0);

    // Write exactly on the STOP->START load edge.
    write_byte(8'hA1);
    repeat (10) @(negedge CLOCK);
    write_byte(8'hB2);
    repeat (27) @(negedge CLOCK);
    check("t4_full_pre", 32'(buf_full), 32'd1);
    write_byte(8'hC3);
    check("t4_full_post", 32'(buf_full), 32'd1);
    check("t4_ovf", 32'(overflow), 32'd0);
    expect_frame("t4a", 8'hA1, 1'b0);
    expect_frame("t4b", 8'hB2, 1'b1);
    expect_frame("t4c", 8'hC3, 1'b1);

    // Reset during data bit 3 with buffer full and overflow set.
    repeat (10) @(negedge CLOCK);
    write_byte(8'h96);
    repeat (4) @(negedge CLOCK);
    write_byte(8'h5A);
    write_byte(8'h5B);
    repeat (10) @(negedge CLOCK);
    check("t5_tx_bit3", 32'(Tx), 32'd0);
    check("t5_full_pre", 32'(buf_full), 32'd1);
    check("t5_ovf_pre", 32'(overflow), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("t5_rst_tx", 32'(Tx), 32'd1);
    check("t5_rst_busy", 32'(tx_busy), 32'd0);
    check("t5_rst_full", 32'(buf_full), 32'd0);
    check("t5_rst_ovf", 32'(overflow), 32'd0);
    @(negedge CLOCK);
    @(negedge CLOCK);
    reset = 1'b0;
    repeat (5) @(negedge CLOCK);
    check("t5_abandoned", 32'(rx_q.size()), 32'd0);
    write_byte(8'h3C);
    expect_frame("t5", 8'h3C, 1'b0);
    repeat (60) @(negedge CLOCK);
    check("t5_no_stale", 32'(rx_q.size()), 32'd0);

    // Loopback stream 00, 55, FF.
    write_byte(8'h00);
    repeat (10) @(negedge CLOCK);
    write_byte(8'h55);
    repeat (27) @(negedge CLOCK);
    write_byte(8'hFF);
    expect_frame("t6a", 8'h00, 1'b0);
    expect_frame("t6b", 8'h55, 1'b1);
    expect_frame("t6c", 8'hFF, 1'b1);
    check("t6_ovf", 32'(overflow), 32'd0);
    repeat (5) @(negedge CLOCK);
    check("t6_idle_tx", 32'(Tx), 32'd1);
    check("t6_idle_busy", 32'(tx_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
